// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the RV32 data-memory access stage:
// datapath width, funct3 access-size encodings, FSM state encoding and
// the size/alignment decode helpers used by the stage and the lane aligner.
package mem_access_stage_pkg;

    // Datapath width; only 32 is supported.
    localparam int XLEN     = 32;
    localparam int FUNCT3_W = 3;

    // funct3 access-size / signedness encodings for loads and stores.
    localparam logic [FUNCT3_W-1:0] LS_B  = 3'b000;
    localparam logic [FUNCT3_W-1:0] LS_H  = 3'b001;
    localparam logic [FUNCT3_W-1:0] LS_W  = 3'b010;
    localparam logic [FUNCT3_W-1:0] LS_BU = 3'b100;
    localparam logic [FUNCT3_W-1:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Access size from funct3; undefined encodings behave as a word access.
    function automatic size_e size_of(input logic [FUNCT3_W-1:0] funct3);
        case (funct3)
            LS_B, LS_BU: size_of = SZ_B;
            LS_H, LS_HU: size_of = SZ_H;
            default:     size_of = SZ_W;
        endcase
    endfunction

    // Unsigned loads zero-extend; everything else sign-extends (or is a word).
    function automatic logic is_unsigned(input logic [FUNCT3_W-1:0] funct3);
        is_unsigned = (funct3 == LS_BU) || (funct3 == LS_HU);
    endfunction

    // Halfwords need addr[0]=0, words need addr[1:0]=0, bytes never fault.
    function automatic logic is_misaligned(input logic [FUNCT3_W-1:0] funct3,
                                           input logic [1:0]          addr_lo);
        case (size_of(funct3))
            SZ_H:    is_misaligned = addr_lo[0];
            SZ_W:    is_misaligned = (addr_lo != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the access stage (master) and the memory (slave).
// req/we/addr/be/wdata are held stable by the master until ack.
interface mem_access_stage_if;
    import mem_access_stage_pkg::*;

    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
    logic            ack;

    modport master (output req, we, addr, be, wdata, input  rdata, ack);
    modport slave  (input  req, we, addr, be, wdata, output rdata, ack);

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic for the access stage: byte-enable
// generation and store-data replication on the store side, lane selection
// and sign/zero extension on the load side.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [FUNCT3_W-1:0] st_funct3,
    input  logic [1:0]          st_addr_lo,
    input  logic [XLEN-1:0]     st_data,
    output logic [3:0]          st_be,
    output logic [XLEN-1:0]     st_lanes,

    input  logic [FUNCT3_W-1:0] ld_funct3,
    input  logic [1:0]          ld_addr_lo,
    input  logic [XLEN-1:0]     ld_raw,
    output logic [XLEN-1:0]     ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: enables follow size and offset, data is replicated per lane.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        st_be    = 4'b1111;
        st_lanes = st_data;
        case (size_of(st_funct3))
            SZ_B: begin
                st_be    = 4'b0001 << st_addr_lo;
                st_lanes = {4{st_data[7:0]}};
            end
            SZ_H: begin
                st_be    = 4'b0011 << st_addr_lo;
                st_lanes = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed lane, then extend to XLEN.
    always_comb begin
        ld_byte = ld_raw[7:0];
        case (ld_addr_lo)
            2'd1:    ld_byte = ld_raw[15:8];
            2'd2:    ld_byte = ld_raw[23:16];
            2'd3:    ld_byte = ld_raw[31:24];
            default: ;
        endcase
        ld_half = ld_addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];

        case (size_of(ld_funct3))
            SZ_B: ld_data = is_unsigned(ld_funct3) ? {24'b0, ld_byte}
                                                   : {{24{ld_byte[7]}}, ld_byte};
            SZ_H: ld_data = is_unsigned(ld_funct3) ? {16'b0, ld_half}
                                                   : {{16{ld_half[15]}}, ld_half};
            default: ld_data = ld_raw;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32 data-memory access stage, between the EX/MEM and MEM/WB latches.
// ALU-only instructions pass through in one cycle; aligned loads/stores
// run one req/ack transaction (IDLE -> BUSY -> RESP) while stall_o freezes
// the upstream pipeline. Misaligned accesses are flagged without a bus cycle.
// Optional: define MEM_TIMEOUT_EN to add out_buserr and a bounded ack wait.
module mem_access_stage
    import mem_access_stage_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic                clk,
    input  logic                rst_n,

    input  logic                in_valid,
    input  logic                in_regwrite,
    input  logic                in_memtoreg,
    input  logic                in_memread,
    input  logic                in_memwrite,
    input  logic [FUNCT3_W-1:0] in_funct3,
    input  logic [XLEN-1:0]     in_alu,
    input  logic [XLEN-1:0]     in_wdata,
    input  logic [4:0]          in_rd,

    output logic                stall_o,

    mem_access_stage_if.master  dmem,

    output logic                out_valid,
    output logic                out_regwrite,
    output logic [4:0]          out_rd,
    output logic [XLEN-1:0]     out_result,
    output logic                out_misalign
`ifdef MEM_TIMEOUT_EN
    ,
    output logic                out_buserr
`endif
);

    state_e state, state_next;

    // Operands captured when a bus transaction starts.
    logic                r_regwrite;
    logic                r_memtoreg;
    logic                r_memread;
    logic [FUNCT3_W-1:0] r_funct3;
    logic [XLEN-1:0]     r_alu;
    logic [4:0]          r_rd;

    logic            accept;
    logic            mem_op;
    logic            misaligned;
    logic            start_bus;
    logic            bus_done;
    logic            timeout;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_lanes;
    logic [XLEN-1:0] ld_data;

    // RESP accepts a new instruction exactly like IDLE.
    assign accept     = in_valid && (state == S_IDLE || state == S_RESP);
    assign mem_op     = in_memread || in_memwrite;
    assign misaligned = is_misaligned(in_funct3, in_alu[1:0]);
    assign start_bus  = accept && mem_op && !misaligned;
    assign bus_done   = (state == S_BUSY) && (dmem.ack || timeout);

    mem_lane_align u_lane_align (
        .st_funct3  (in_funct3),
        .st_addr_lo (in_alu[1:0]),
        .st_data    (in_wdata),
        .st_be      (st_be),
        .st_lanes   (st_lanes),
        .ld_funct3  (r_funct3),
        .ld_addr_lo (r_alu[1:0]),
        .ld_raw     (dmem.rdata),
        .ld_data    (ld_data)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] busy_cnt;

    assign timeout = (state == S_BUSY) && !dmem.ack &&
                     (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count BUSY cycles; cleared whenever the FSM is not waiting in BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
        end else if (state == S_BUSY && !bus_done) begin
            busy_cnt <= busy_cnt + 1'b1;
        end else begin
            busy_cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_RESP: state_next = start_bus ? S_BUSY : S_IDLE;
            S_BUSY:         state_next = bus_done  ? S_RESP : S_BUSY;
            default:        state_next = S_IDLE;
        endcase
    end

    // FSM outputs: stall from the issue cycle through the last BUSY cycle.
    always_comb begin
        stall_o = (state == S_BUSY) || start_bus;
    end

    // Bus drive, operand capture and the one-cycle result toward MEM/WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem.req     <= 1'b0;
            dmem.we      <= 1'b0;
            dmem.addr    <= '0;
            dmem.be      <= 4'b0000;
            dmem.wdata   <= '0;
            r_regwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_memread    <= 1'b0;
            r_funct3     <= '0;
            r_alu        <= '0;
            r_rd         <= '0;
            out_valid    <= 1'b0;
            out_regwrite <= 1'b0;
            out_rd       <= '0;
            out_result   <= '0;
            out_misalign <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            out_buserr   <= 1'b0;
`endif
        end else begin
            out_valid    <= 1'b0;
            out_regwrite <= 1'b0;
            out_misalign <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            out_buserr   <= 1'b0;
`endif
            if (start_bus) begin
                dmem.req   <= 1'b1;
                dmem.we    <= in_memwrite;
                dmem.addr  <= {in_alu[XLEN-1:2], 2'b00};
                dmem.be    <= st_be;
                dmem.wdata <= st_lanes;
                r_regwrite <= in_regwrite;
                r_memtoreg <= in_memtoreg;
                r_memread  <= in_memread;
                r_funct3   <= in_funct3;
                r_alu      <= in_alu;
                r_rd       <= in_rd;
            end else if (accept) begin
                // ALU pass-through, or a misaligned access reported without a bus cycle.
                out_valid    <= 1'b1;
                out_rd       <= in_rd;
                out_result   <= in_alu;
                out_regwrite <= in_regwrite && !(mem_op && misaligned);
                out_misalign <= mem_op && misaligned;
            end

            if (bus_done) begin
                dmem.req     <= 1'b0;
                dmem.we      <= 1'b0;
                dmem.be      <= 4'b0000;
                out_valid    <= 1'b1;
                out_rd       <= r_rd;
                out_result   <= (r_memread && r_memtoreg && !timeout) ? ld_data : r_alu;
                out_regwrite <= r_regwrite && !timeout;
`ifdef MEM_TIMEOUT_EN
                out_buserr   <= timeout;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a vector table for single-cycle
// results (ALU pass-through, misaligned accesses) plus hand-written
// sequences for bus transactions, reset during BUSY and the ack timeout.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_regwrite, in_memtoreg, in_memread, in_memwrite;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu, in_wdata;
    logic [4:0]  in_rd;
    logic        stall_o;
    logic        out_valid, out_regwrite, out_misalign;
    logic [4:0]  out_rd;
    logic [31:0] out_result;
`ifdef MEM_TIMEOUT_EN
    logic        out_buserr;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_stage_if dmem ();

    mem_access_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_regwrite  (in_regwrite),
        .in_memtoreg  (in_memtoreg),
        .in_memread   (in_memread),
        .in_memwrite  (in_memwrite),
        .in_funct3    (in_funct3),
        .in_alu       (in_alu),
        .in_wdata     (in_wdata),
        .in_rd        (in_rd),
        .stall_o      (stall_o),
        .dmem         (dmem),
        .out_valid    (out_valid),
        .out_regwrite (out_regwrite),
        .out_rd       (out_rd),
        .out_result   (out_result),
        .out_misalign (out_misalign)
`ifdef MEM_TIMEOUT_EN
        ,
        .out_buserr   (out_buserr)
`endif
    );

    typedef struct {
        string       name;
        logic        rw, m2r, mr, mw;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [4:0]  rd;
        bit          chk_res;
        logic [31:0] e_result;
        logic        e_rw, e_mis;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, rw, m2r, mr, mw, input logic [2:0] f3,
                         input logic [31:0] alu, wd, input logic [4:0] rd);
        in_valid    = v;
        in_regwrite = rw;
        in_memtoreg = m2r;
        in_memread  = mr;
        in_memwrite = mw;
        in_funct3   = f3;
        in_alu      = alu;
        in_wdata    = wd;
        in_rd       = rd;
    endtask

    // Issue one memory op, ack after 'delay' BUSY cycles, check the RESP cycle.
    // Returns at the falling edge inside RESP with in_valid low.
    task automatic bus_op(input string name, input logic rw, m2r, mr, mw,
                          input logic [2:0] f3, input logic [31:0] alu, wd,
                          input int delay, input logic [31:0] rdata,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, e_result, input logic e_rw);
        int stall_cycles = 0;
        @(negedge clk);
        drive(1'b1, rw, m2r, mr, mw, f3, alu, wd, 5'd12);
        #1;
        check({name, " stall in issue cycle"}, stall_o, 1);
        check({name, " req before BUSY"}, dmem.req, 0);
        if (stall_o) stall_cycles++;
        for (int k = 1; k <= delay; k++) begin
            @(negedge clk);
            in_valid   = 1'b0;
            dmem.rdata = 32'hDEAD_0000;
            if (stall_o) stall_cycles++;
            check({name, " req"},  dmem.req, 1);
            check({name, " addr"}, dmem.addr, e_addr);
            check({name, " be"},   dmem.be, e_be);
            check({name, " we"},   dmem.we, mw);
            if (mw) check({name, " wdata"}, dmem.wdata, e_wdata);
            check({name, " out_valid while BUSY"}, out_valid, 0);
            if (k == delay) begin
                dmem.ack   = 1'b1;
                dmem.rdata = rdata;
            end
        end
        @(negedge clk);
        dmem.ack   = 1'b0;
        dmem.rdata = 32'h5A5A_5A5A;
        check({name, " out_valid"},    out_valid, 1);
        check({name, " stall in RESP"}, stall_o, 0);
        check({name, " req after ack"}, dmem.req, 0);
        check({name, " out_result"},   out_result, e_result);
        check({name, " out_regwrite"}, out_regwrite, e_rw);
        check({name, " out_rd"},       out_rd, 12);
        check({name, " out_misalign"}, out_misalign, 0);
`ifdef MEM_TIMEOUT_EN
        check({name, " out_buserr"},   out_buserr, 0);
`endif
        check({name, " stall cycles"}, stall_cycles, delay + 1);
    endtask

    initial begin
        //          name        rw  m2r mr  mw  f3      alu            rd  chk  result         rw  mis
        vecs[0] = '{"alu 1234", 1, 0, 0, 0, 3'b000, 32'h0000_1234, 5'd5,  1, 32'h0000_1234, 1, 0};
        vecs[1] = '{"alu no-wb", 0, 0, 0, 0, 3'b010, 32'hDEAD_BEEF, 5'd31, 1, 32'hDEAD_BEEF, 0, 0};
        vecs[2] = '{"misal lw",  1, 1, 1, 0, 3'b010, 32'h0000_0402, 5'd7,  0, 32'h0,         0, 1};
        vecs[3] = '{"misal lh",  1, 1, 1, 0, 3'b001, 32'h0000_0011, 5'd8,  0, 32'h0,         0, 1};
        vecs[4] = '{"misal sw",  0, 0, 0, 1, 3'b010, 32'h0000_0703, 5'd0,  0, 32'h0,         0, 1};
        vecs[5] = '{"misal lhu", 1, 1, 1, 0, 3'b101, 32'h0000_0005, 5'd9,  0, 32'h0,         0, 1};
        vecs[6] = '{"misal f3=011 as W", 1, 1, 1, 0, 3'b011, 32'h0000_0006, 5'd10, 0, 32'h0, 0, 1};
        vecs[7] = '{"misal f3=110 as W", 1, 1, 1, 0, 3'b110, 32'h0000_0001, 5'd11, 0, 32'h0, 0, 1};

        rst_n      = 1'b0;
        dmem.ack   = 1'b0;
        dmem.rdata = 32'h5A5A_5A5A;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        #1;
        check("reset req",       dmem.req, 0);
        check("reset we",        dmem.we, 0);
        check("reset be",        dmem.be, 0);
        check("reset addr",      dmem.addr, 0);
        check("reset wdata",     dmem.wdata, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_rw",    out_regwrite, 0);
        check("reset out_mis",   out_misalign, 0);
        check("reset out_result", out_result, 0);
        check("reset out_rd",    out_rd, 0);
        check("reset stall",     stall_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        check("idle out_valid", out_valid, 0);

        // Single-cycle results from the vector table.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(1'b1, vecs[i].rw, vecs[i].m2r, vecs[i].mr, vecs[i].mw, vecs[i].f3,
                  vecs[i].alu, 32'h0, vecs[i].rd);
            #1;
            check({vecs[i].name, " stall"}, stall_o, 0);
            @(negedge clk);
            in_valid = 1'b0;
            check({vecs[i].name, " out_valid"}, out_valid, 1);
            if (vecs[i].chk_res) check({vecs[i].name, " out_result"}, out_result, vecs[i].e_result);
            check({vecs[i].name, " out_rd"},       out_rd, vecs[i].rd);
            check({vecs[i].name, " out_regwrite"}, out_regwrite, vecs[i].e_rw);
            check({vecs[i].name, " out_misalign"}, out_misalign, vecs[i].e_mis);
            check({vecs[i].name, " no bus req"},   dmem.req, 0);
        end
        @(negedge clk);
        check("out_valid drops after pulse", out_valid, 0);

        // ack outside BUSY must be ignored.
        dmem.ack = 1'b1;
        @(negedge clk);
        dmem.ack = 1'b0;
        check("stray ack out_valid", out_valid, 0);
        check("stray ack req",       dmem.req, 0);

        //     name   rw    m2r   mr    mw    f3      alu            wdata          dly rdata          addr           be       wdata          result         rw
        bus_op("lb",  1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,         3, 32'h80FF_FFFF, 32'h0000_0100, 4'b1000, 32'h0,         32'hFFFF_FF80, 1'b1);
        bus_op("lhu", 1'b1, 1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0,         1, 32'hBEEF_0000, 32'h0000_0200, 4'b1100, 32'h0,         32'h0000_BEEF, 1'b1);
        bus_op("sb",  1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_00AB, 2, 32'h0,         32'h0000_0300, 4'b0010, 32'hABAB_ABAB, 32'h0000_0301, 1'b0);
        bus_op("lh",  1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0,         1, 32'h8001_0000, 32'h0000_0200, 4'b1100, 32'h0,         32'hFFFF_8001, 1'b1);
        bus_op("lbu", 1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0,         2, 32'h0000_F200, 32'h0000_0100, 4'b0010, 32'h0,         32'h0000_00F2, 1'b1);
        bus_op("sh",  1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 32'h0000_0602, 32'h1234_CDEF, 1, 32'h0,         32'h0000_0600, 4'b1100, 32'hCDEF_CDEF, 32'h0000_0602, 1'b0);
        bus_op("sw",  1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0700, 32'hCAFE_F00D, 1, 32'h0,         32'h0000_0700, 4'b1111, 32'hCAFE_F00D, 32'h0000_0700, 1'b0);
        bus_op("f3=111 load as W", 1'b1, 1'b1, 1'b1, 1'b0, 3'b111, 32'h0000_0800, 32'h0, 1, 32'h89AB_CDEF, 32'h0000_0800, 4'b1111, 32'h0, 32'h89AB_CDEF, 1'b1);
        bus_op("lw",  1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0,         1, 32'h1234_5678, 32'h0000_0500, 4'b1111, 32'h0,         32'h1234_5678, 1'b1);

        // New instruction accepted in the RESP cycle.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd9);
        #1;
        check("resp accept stall", stall_o, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("resp accept out_valid",  out_valid, 1);
        check("resp accept out_result", out_result, 32'h0000_0055);
        check("resp accept out_rd",     out_rd, 9);

`ifndef MEM_TIMEOUT_EN
        // Without the timeout, BUSY waits as long as the memory needs.
        bus_op("slow lw", 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0A00, 32'h0, 20, 32'h0BAD_F00D, 32'h0000_0A00, 4'b1111, 32'h0, 32'h0BAD_F00D, 1'b1);
`endif

        // Reset asserted in BUSY: req drops at once and no result emerges.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0900, 32'h0, 5'd3);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre-reset req", dmem.req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset-in-busy req",       dmem.req, 0);
        check("reset-in-busy stall",     stall_o, 0);
        check("reset-in-busy out_valid", out_valid, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        dmem.ack = 1'b1;
        @(negedge clk);
        dmem.ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("after reset out_valid", out_valid, 0);
            check("after reset req",       dmem.req, 0);
            @(negedge clk);
        end

`ifdef MEM_TIMEOUT_EN
        // No ack: give up on the 16th BUSY cycle with a bus error.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0A00, 32'h0, 5'd4);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("timeout wait req", dmem.req, 1);
        end
        @(negedge clk);
        check("timeout out_valid",    out_valid, 1);
        check("timeout out_buserr",   out_buserr, 1);
        check("timeout out_regwrite", out_regwrite, 0);
        check("timeout req",          dmem.req, 0);
        @(negedge clk);
        check("timeout buserr clears", out_buserr, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
